// File: rtl/javk_biu.sv
// JAVK bus interface unit: splits one multi-beat core request into single-beat bus
// cycles with wait states, memory ready, little-endian packing and read-after-write turnaround.
module javk_biu #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAX_BEATS   = 4,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned LEN_W       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    inout  wire logic [DATA_W-1:0]        databus,
    output logic [ADDR_W-1:0]             addrbus,
    output logic                          rw,
    input  logic                          mem_ready,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [LEN_W-1:0]              req_len,
    input  logic [MAX_BEATS*DATA_W-1:0]   req_wdata,
    output logic                          rsp_valid,
    output logic [MAX_BEATS*DATA_W-1:0]   rsp_rdata,
    output logic                          busy
);

    localparam int unsigned BUS_W  = MAX_BEATS * DATA_W;
    localparam int unsigned WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StTurn, StBeat, StDone} state_e;

    state_e              state_q, state_d;
    logic                we_q;
    logic                rw_q;
    logic                prev_wr_q;
    logic [LEN_W-1:0]    last_q;
    logic [LEN_W-1:0]    beat_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BUS_W-1:0]    wdata_q;
    logic [BUS_W-1:0]    acc_q, acc_d;
    logic [BUS_W-1:0]    rsp_q;
    logic [LEN_W-1:0]    last_idx;
    logic                accept;
    logic                wait_done;
    logic                beat_end;
    logic                bus_oe;

    assign accept    = (state_q == StIdle) && req_valid && !rst;
    assign wait_done = (32'(wait_q) >= WAIT_STATES);
    assign beat_end  = (state_q == StBeat) && wait_done && mem_ready;

    // Out-of-range lengths are clamped to the nearest legal beat count.
    always_comb begin
        if (req_len == '0) begin
            last_idx = '0;
        end else if (req_len > LEN_W'(MAX_BEATS)) begin
            last_idx = LEN_W'(MAX_BEATS - 1);
        end else begin
            last_idx = req_len - LEN_W'(1);
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (beat_end && !we_q) begin
            acc_d[32'(beat_q) * DATA_W +: DATA_W] = databus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (!req_we && prev_wr_q) ? StTurn : StBeat;
                end
            end
            StTurn: state_d = StBeat;
            StBeat: begin
                if (beat_end && (beat_q == last_q)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle) && !rst;
        busy      = (state_q != StIdle);
        rsp_valid = (state_q == StDone);
        bus_oe    = (state_q == StBeat) && we_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            rw_q      <= 1'b1;
            prev_wr_q <= 1'b0;
            last_q    <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            acc_q     <= '0;
            rsp_q     <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                last_q  <= last_idx;
                beat_q  <= '0;
                wait_q  <= '0;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                acc_q   <= '0;
                // rw stays at write through TURN so neither side drives the bus.
                if (state_d == StBeat) begin
                    rw_q <= !req_we;
                end
            end
            if (state_q == StTurn) begin
                rw_q <= !we_q;
            end
            if (state_q == StBeat) begin
                prev_wr_q <= we_q;
                acc_q     <= acc_d;
                if (beat_end) begin
                    wait_q <= '0;
                    if (beat_q != last_q) begin
                        beat_q <= beat_q + LEN_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end else if (!we_q) begin
                        rsp_q <= acc_d;
                    end
                end else if (!wait_done) begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
            end
        end
    end

    assign addrbus   = addr_q;
    assign rw        = rw_q;
    assign rsp_rdata = rsp_q;
    assign databus   = bus_oe ? wdata_q[32'(beat_q) * DATA_W +: DATA_W] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_javk_biu.sv
// Randomised bench for javk_biu: a behavioural memory plus a per-request reference model
// predicting bus address/data per cycle, response timing and packed read data.
module tb_javk_biu;

    localparam int unsigned WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    wire  [7:0]  databus;
    logic [15:0] addrbus;
    logic        rw;
    logic        mem_ready;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [2:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic        mem_good;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          prev_write;
    logic [31:0] rsp_model;

    // Memory drives the bus while rw is high; it shows inverted data except on the
    // cycle the beat is supposed to end, so an early sample is caught.
    assign databus = rw ? (mem_good ? mem[addrbus] : ~mem[addrbus]) : 8'bz;

    javk_biu #(
        .ADDR_W(16), .DATA_W(8), .MAX_BEATS(4), .WAIT_STATES(WS), .LEN_W(3)
    ) dut (
        .clk(clk), .rst(rst), .databus(databus), .addrbus(addrbus), .rw(rw),
        .mem_ready(mem_ready), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request; stall < 0 gives random mem_ready, stall >= 0 holds it low that many
    // cycles after the wait count. abort_beat >= 0 asserts rst at the start of that beat.
    task automatic run_req(input bit we, input logic [15:0] addr, input logic [2:0] len,
                           input logic [31:0] wdata, input int stall, input int abort_beat);
        int          eff, n, k, lows;
        bit          turn, rdy, ended;
        logic [31:0] asm_data;
        logic [15:0] a;
        eff  = (len == 0) ? 1 : ((len > 4) ? 4 : int'(len));
        turn = !we && prev_write;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_eq("ready_timeout", req_ready, 1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wdata;
        mem_good = 1'b0; mem_ready = 1'($urandom % 2);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("busy_after_accept", busy, 1);
        check_eq("ready_after_accept", req_ready, 0);
        if (turn) begin
            check_eq("turn_oe", dut.bus_oe, 0);
            check_eq("turn_rsp", rsp_valid, 0);
            mem_ready = 1'($urandom % 2);
            @(negedge clk);
        end
        asm_data = '0;
        for (int i = 0; i < eff; i++) begin
            a = addr + 16'(i);
            k = 0; lows = 0; ended = 1'b0;
            while (!ended) begin
                check_eq("addr", addrbus, a);
                check_eq("rw", rw, !we);
                check_eq("oe", dut.bus_oe, we);
                if (we) check_eq("wdata", databus, wdata[i*8 +: 8]);
                check_eq("rsp_in_beat", rsp_valid, 0);
                if (abort_beat == i && k == 0) begin
                    rst = 1'b1;
                    mem_ready = 1'($urandom % 2);
                    @(negedge clk);
                    check_eq("rst_oe", dut.bus_oe, 0);
                    check_eq("rst_rw", rw, 1);
                    check_eq("rst_addr", addrbus, 0);
                    check_eq("rst_busy", busy, 0);
                    check_eq("rst_rsp", rsp_valid, 0);
                    check_eq("rst_ready", req_ready, 0);
                    rst = 1'b0; rsp_model = '0; prev_write = 1'b0;
                    @(negedge clk);
                    check_eq("post_rst_ready", req_ready, 1);
                    check_eq("post_rst_rdata", rsp_rdata, 0);
                    check_eq("post_rst_rsp", rsp_valid, 0);
                    return;
                end
                if (k < int'(WS)) rdy = (stall >= 0) ? 1'b1 : 1'($urandom % 2);
                else if (stall >= 0) rdy = (k >= int'(WS) + stall);
                else rdy = (lows >= 3) || ($urandom % 2 == 1);
                if (k >= int'(WS) && !rdy) lows++;
                ended = (k >= int'(WS)) && rdy;
                mem_ready = rdy;
                mem_good = ended;
                if (ended && !we) asm_data[i*8 +: 8] = mem[a];
                @(negedge clk);
                mem_good = 1'b0;
                if (ended && we) mem[a] = wdata[i*8 +: 8];
                k++;
            end
        end
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("done_oe", dut.bus_oe, 0);
        check_eq("done_ready", req_ready, 0);
        if (!we) rsp_model = asm_data;
        check_eq("rsp_rdata", rsp_rdata, rsp_model);
        prev_write = we;
        mem_ready = 1'($urandom % 2);
        @(negedge clk);
        check_eq("rsp_pulse_end", rsp_valid, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_ready", req_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1; mem_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_len = '0; req_wdata = '0; mem_good = 1'b0;
        prev_write = 1'b0; rsp_model = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_addr", addrbus, 0);
        check_eq("reset_rw", rw, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_rsp", rsp_valid, 0);
        check_eq("reset_ready", req_ready, 0);
        check_eq("reset_rdata", rsp_rdata, 0);
        check_eq("reset_oe", dut.bus_oe, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", req_ready, 1);

        mem[16'h1234] = 8'h11;
        mem[16'h1235] = 8'h22;
        run_req(1'b0, 16'h1234, 3'd2, 32'h0, 0, -1);
        check_eq("read2_rdata", rsp_rdata, 32'h0000_2211);
        run_req(1'b1, 16'hFFFE, 3'd4, 32'hDDCC_BBAA, 0, -1);
        check_eq("wrap_mem", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]},
                 32'hDDCC_BBAA);
        run_req(1'b0, 16'h0010, 3'd1, 32'h0, 3, -1);
        run_req(1'b1, 16'h0040, 3'd1, 32'h5A, 0, -1);
        run_req(1'b0, 16'h0040, 3'd1, 32'h0, 0, -1);
        check_eq("turn_readback", rsp_rdata, 32'h5A);
        run_req(1'b0, 16'h2000, 3'd0, 32'h0, 0, -1);
        run_req(1'b0, 16'h3000, 3'd7, 32'h0, 1, -1);
        run_req(1'b1, 16'h4000, 3'd7, 32'h1234_5678, -1, -1);
        run_req(1'b1, 16'h0100, 3'd4, 32'hCAFE_F00D, 0, 1);

        for (int t = 0; t < 40; t++) begin
            run_req(1'($urandom % 2), 16'($urandom), 3'($urandom % 8), $urandom,
                    ($urandom % 3 == 0) ? int'($urandom % 4) : -1,
                    ($urandom % 10 == 0) ? int'($urandom % 4) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
